// File: rtl/parity_serial_tx_if.sv
// Handshake and serial-output bundle for parity_serial_tx.
// The master drives the word offer; the slave (the transmitter) drives everything else.
interface parity_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             msb_first;
  logic             in_ready;
  logic             tx_bit;
  logic             tx_valid;
  logic             tx_last;
  logic             busy;
  logic [2:0]       res5;

  modport master (
    output in_valid, in_data, msb_first,
    input  in_ready, tx_bit, tx_valid, tx_last, busy, res5
  );

  modport slave (
    input  in_valid, in_data, msb_first,
    output in_ready, tx_bit, tx_valid, tx_last, busy, res5
  );
endinterface

// File: rtl/parity_serial_tx.sv
// Parallel-to-serial transmitter: WIDTH data bits in selectable order followed by
// one parity bit, with a running mod-5 remainder of the data bits sent so far.
module parity_serial_tx #(
  parameter int WIDTH      = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  parity_serial_tx_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam int         CW     = $clog2(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             par_bit;
  logic [2:0]       res5;
  logic             tx_bit;
  logic             tx_valid;
  logic             tx_last;

  logic             accept;
  logic [WIDTH-1:0] ordered;
  logic [3:0]       res5_dbl;
  logic [2:0]       res5_next;

  assign bus.in_ready = (state != DATA);
  assign accept       = bus.in_valid && (state != DATA);

  // Present the word so that transmit order always runs from bit WIDTH-1 down.
  always_comb begin
    ordered = bus.in_data;
    if (!bus.msb_first) begin
      for (int i = 0; i < WIDTH; i++) ordered[i] = bus.in_data[WIDTH-1-i];
    end
  end

  // 2*res5 + b never exceeds 9, so a single conditional subtract reduces it.
  assign res5_dbl  = {res5, 1'b0} + {3'b000, tx_bit};
  assign res5_next = (res5_dbl >= 4'd5) ? 3'(res5_dbl - 4'd5) : res5_dbl[2:0];

  // NOTE: every register, including the data shifter, sits under the async reset
  // so an aborted frame leaves nothing stale; state updates use non-blocking only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      res5     <= 3'd0;
      tx_bit   <= 1'b0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
    end else begin
      case (state)
        DATA: begin
          res5 <= res5_next;
          if (cnt == CW'(WIDTH - 1)) begin
            state   <= PARITY;
            tx_bit  <= par_bit;
            tx_last <= 1'b1;
          end else begin
            cnt    <= cnt + 1'b1;
            tx_bit <= shreg[WIDTH-1];
            shreg  <= {shreg[WIDTH-2:0], 1'b0};
          end
        end
        default: begin
          // IDLE and PARITY both accept; PARITY chains straight into the next frame.
          if (accept) begin
            state    <= DATA;
            cnt      <= '0;
            res5     <= 3'd0;
            par_bit  <= (^bus.in_data) ^ PARITY_ODD;
            tx_bit   <= ordered[WIDTH-1];
            shreg    <= {ordered[WIDTH-2:0], 1'b0};
            tx_valid <= 1'b1;
            tx_last  <= 1'b0;
          end else begin
            state    <= IDLE;
            tx_bit   <= 1'b0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.tx_bit   = tx_bit;
  assign bus.tx_valid = tx_valid;
  assign bus.tx_last  = tx_last;
  assign bus.busy     = (state != IDLE);
  assign bus.res5     = res5;
endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx: an even-parity and an odd-parity instance
// share one stimulus stream; expected bit streams are written out by hand.
module tb_parity_serial_tx;
  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  bit   odd_sel;

  parity_serial_tx_if #(.WIDTH(WIDTH)) bus ();
  parity_serial_tx_if #(.WIDTH(WIDTH)) bus_odd ();

  assign bus_odd.in_valid  = bus.in_valid;
  assign bus_odd.in_data   = bus.in_data;
  assign bus_odd.msb_first = bus.msb_first;

  parity_serial_tx #(.WIDTH(WIDTH), .PARITY_ODD(1'b0)) u_even (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  parity_serial_tx #(.WIDTH(WIDTH), .PARITY_ODD(1'b1)) u_odd (
    .clk (clk),
    .rst (rst),
    .bus (bus_odd)
  );

  logic       o_bit, o_valid, o_last, o_busy, o_ready;
  logic [2:0] o_res5;

  always_comb begin
    o_bit   = odd_sel ? bus_odd.tx_bit   : bus.tx_bit;
    o_valid = odd_sel ? bus_odd.tx_valid : bus.tx_valid;
    o_last  = odd_sel ? bus_odd.tx_last  : bus.tx_last;
    o_busy  = odd_sel ? bus_odd.busy     : bus.busy;
    o_ready = odd_sel ? bus_odd.in_ready : bus.in_ready;
    o_res5  = odd_sel ? bus_odd.res5     : bus.res5;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag, input logic [2:0] exp_res5);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_last"},  32'(o_last),  32'd0);
    check({tag, "_bit"},   32'(o_bit),   32'd0);
    check({tag, "_busy"},  32'(o_busy),  32'd0);
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
    check({tag, "_res5"},  32'(o_res5),  32'(exp_res5));
  endtask

  // Called on a negedge with the DUT idle; exp_seq lists tx_bit in transmit order, MSB first.
  task automatic send_frame(input string tag, input logic [WIDTH-1:0] data, input logic msb,
                            input logic [WIDTH-1:0] exp_seq, input logic exp_par,
                            input logic [2:0] exp_res5, input bit odd, input bit poke);
    odd_sel       = odd;
    bus.in_valid  = 1'b1;
    bus.in_data   = data;
    bus.msb_first = msb;
    #1 check({tag, "_ready_pre"}, 32'(o_ready), 32'd1);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_data   = ~data;
    bus.msb_first = ~msb;
    for (int i = 0; i < WIDTH; i++) begin
      check({tag, "_dvalid"}, 32'(o_valid), 32'd1);
      check({tag, "_dbit"},   32'(o_bit),   32'(exp_seq[WIDTH-1-i]));
      check({tag, "_dlast"},  32'(o_last),  32'd0);
      check({tag, "_dbusy"},  32'(o_busy),  32'd1);
      check({tag, "_dready"}, 32'(o_ready), 32'd0);
      if (poke && i == 2) bus.in_valid = 1'b1;
      if (poke && i == WIDTH - 2) bus.in_valid = 1'b0;
      @(negedge clk);
    end
    check({tag, "_pvalid"}, 32'(o_valid), 32'd1);
    check({tag, "_plast"},  32'(o_last),  32'd1);
    check({tag, "_pbit"},   32'(o_bit),   32'(exp_par));
    check({tag, "_pready"}, 32'(o_ready), 32'd1);
    check({tag, "_pbusy"},  32'(o_busy),  32'd1);
    check({tag, "_pres5"},  32'(o_res5),  32'(exp_res5));
    @(negedge clk);
    check_idle({tag, "_end"}, exp_res5);
  endtask

  initial begin
    logic [17:0] exp18;
    logic [7:0]  a5_seq;
    n_checks      = 0;
    n_fail        = 0;
    odd_sel       = 1'b0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.msb_first = 1'b0;

    repeat (2) @(negedge clk);
    check_idle("reset", 3'd0);
    rst = 1'b1;

    send_frame("a5_msb", 8'hA5, 1'b1, 8'b10100101, 1'b0, 3'd0, 1'b0, 1'b0);
    send_frame("0b_lsb", 8'h0B, 1'b0, 8'b11010000, 1'b1, 3'd3, 1'b0, 1'b0);
    send_frame("odd_00", 8'h00, 1'b1, 8'b00000000, 1'b1, 3'd0, 1'b1, 1'b0);
    send_frame("poke",   8'h12, 1'b0, 8'b01001000, 1'b0, 3'd2, 1'b0, 1'b1);
    @(negedge clk);
    check_idle("poke_no_second", 3'd2);

    // Back-to-back: second word accepted during the first frame's parity cycle.
    odd_sel       = 1'b0;
    exp18         = 18'b11111111_0_00000001_1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hFF;
    bus.msb_first = 1'b1;
    @(negedge clk);
    bus.in_data = 8'h01;
    for (int i = 0; i < 18; i++) begin
      check("b2b_valid", 32'(o_valid), 32'd1);
      check("b2b_bit",   32'(o_bit),   32'(exp18[17-i]));
      check("b2b_last",  32'(o_last),  32'((i == 8) || (i == 17)));
      if (i == 8) check("b2b_res5_first", 32'(o_res5), 32'd0);
      if (i == 9) bus.in_valid = 1'b0;
      @(negedge clk);
    end
    check_idle("b2b_end", 3'd1);

    // Reset lands while the 4th data bit is on the wire.
    a5_seq        = 8'b10100101;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA5;
    bus.msb_first = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_pre_bit", 32'(o_bit), 32'(a5_seq[7-i]));
      @(negedge clk);
    end
    check("rst_pre_valid", 32'(o_valid), 32'd1);
    rst = 1'b0;
    #1 check_idle("rst_async", 3'd0);
    @(negedge clk);
    check_idle("rst_held", 3'd0);
    rst = 1'b1;
    send_frame("post_rst", 8'h81, 1'b1, 8'b10000001, 1'b0, 3'd4, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/parity_serial_tx.md
PARITY_SERIAL_TX -- requirements
Module: parity_serial_tx

Interface
REQ-001 Parameter WIDTH, default 8, sets the number of data bits per word (WIDTH >= 2).
REQ-002 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  a word is offered on in_data.
REQ-006 in_data  input  WIDTH  parallel word to transmit.
REQ-007 msb_first  input  1  bit order for the offered word (1 = MSB first, 0 = LSB first); sampled only at accept.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 tx_bit  output  1  serial output bit.
REQ-010 tx_valid  output  1  tx_bit carries a data or parity bit this cycle.
REQ-011 tx_last  output  1  the current tx_bit is the parity (final) bit of the frame.
REQ-012 busy  output  1  a frame is in progress (DATA or PARITY state).
REQ-013 res5  output  3  running remainder mod 5 of the data bits transmitted so far in the current frame.

Function
REQ-014 The FSM SHALL have three states: IDLE, DATA, PARITY.
REQ-015 in_ready SHALL be 1 in IDLE and in PARITY, and 0 in DATA.
REQ-016 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data, msb_first and the computed parity bit are latched at accept.
REQ-017 On accept, the FSM SHALL enter DATA; a bit counter SHALL clear and res5 SHALL clear to 0.
REQ-018 Latency: the first data bit SHALL appear on tx_bit, with tx_valid=1, in the cycle immediately after the accept edge; tx_bit, tx_valid and tx_last are registered.
REQ-019 DATA SHALL last exactly WIDTH cycles, emitting in_data[WIDTH-1] down to [0] when msb_first=1, and [0] up to [WIDTH-1] when msb_first=0.
REQ-020 After the WIDTH-th data bit, the FSM SHALL enter PARITY for exactly 1 cycle with tx_valid=1 and tx_last=1.
REQ-021 The parity bit SHALL equal ^in_data XOR PARITY_ODD, so that the total count of ones over data plus parity is even (PARITY_ODD=0) or odd (PARITY_ODD=1).
REQ-022 At the end of PARITY: if an accept occurs in that cycle, the FSM SHALL go directly to DATA with no gap cycle; otherwise it SHALL go to IDLE.
REQ-023 In IDLE, tx_valid=0, tx_last=0, tx_bit=0, and busy=0.
REQ-024 Each rising edge that ends a DATA cycle with bit b SHALL update res5 to (2*res5 + b) mod 5, using the bits in transmitted order regardless of msb_first.
REQ-025 res5 SHALL be in the range 0-4 at all times.
REQ-026 res5 SHALL hold the full-word remainder from the PARITY cycle until the next accept.
REQ-027 in_valid, in_data and msb_first SHALL be ignored while in_ready=0; changing them mid-frame SHALL NOT affect the frame in progress.
REQ-028 An in_valid pulse asserted while in_ready=0 SHALL NOT be remembered.

Reset
REQ-029 While rst=0, the block SHALL asynchronously force state=IDLE, in_ready=1, tx_bit=0, tx_valid=0, tx_last=0, busy=0, res5=0, and bit counter=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately; no parity bit is emitted for it.
REQ-031 The first accept after reset SHALL be possible on the first rising edge with rst=1.

Verification
REQ-032 Scenario: WIDTH=8, msb_first=1, in_data=8'hA5 -> tx_bit 1,0,1,0,0,1,0,1 then parity 0 with tx_last=1; res5=0 (165 mod 5).
REQ-033 Scenario: msb_first=0, in_data=8'h0B -> tx_bit 1,1,0,1,0,0,0,0 then parity 1; res5=3 (sequence 0xD0 = 208 mod 5).
REQ-034 Scenario: in_valid held high with 8'hFF then 8'h01, msb_first=1 -> second word accepted in the PARITY cycle; 18 consecutive tx_valid cycles; parities 0 then 1; final res5=1.
REQ-035 Scenario: PARITY_ODD=1, in_data=8'h00 -> eight 0 bits then parity 1.
REQ-036 Scenario: in_valid=1 with new in_data during DATA -> in_ready=0, no accept, the current frame is unchanged, and no second frame follows unless in_valid is still high in PARITY.
REQ-037 Scenario: rst driven low on the 4th data bit -> same cycle tx_valid=0, busy=0, in_ready=1, res5=0; the next accept starts a clean frame.
